// File: rtl/avl_arbiter_pkg.sv
// Shared configuration for the two-port Avalon-MM arbiter: window and watchdog
// defaults, port ids and the controller state encoding.
package avl_arbiter_pkg;

  localparam logic [31:0] AVL_BASE_ADDR_DEFAULT  = 32'h8000_0000;
  localparam logic [31:0] AVL_TOP_ADDR_DEFAULT   = 32'h9000_0000;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1023;

  localparam logic PORT_IMEM = 1'b0;
  localparam logic PORT_DMEM = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CMD    = 2'd1,
    S_RDWAIT = 2'd2,
    S_RESP   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/avl_arbiter.sv
// Round-robin arbiter joining an instruction and a data request port onto one
// Avalon-MM master, one transaction in flight, with window check and read watchdog.
module avl_arbiter
  import avl_arbiter_pkg::*;
#(
  parameter logic [31:0] avl_base_addr  = AVL_BASE_ADDR_DEFAULT,
  parameter logic [31:0] avl_top_addr   = AVL_TOP_ADDR_DEFAULT,
  parameter int unsigned timeout_cycles = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  output logic        imem_error,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        dmem_error,
  output logic [31:0] avl_address,
  output logic        avl_read,
  output logic        avl_write,
  output logic [31:0] avl_writedata,
  output logic [3:0]  avl_byteenable,
  input  logic        avl_waitrequest,
  input  logic [31:0] avl_readdata,
  input  logic        avl_readdatavalid,
  output logic [1:0]  dbg_state
);

  localparam int WD_W = $clog2(timeout_cycles + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(timeout_cycles - 1);

  arb_state_e        state_q;
  logic              last_q;
  logic              port_q;
  logic              is_write_q;
  logic [WD_W-1:0]   wd_q;
  logic              resp_err_q;
  logic [31:0]       resp_rdata_q;
  logic [31:0]       avl_address_q;
  logic              avl_read_q;
  logic              avl_write_q;
  logic [31:0]       avl_writedata_q;
  logic [3:0]        avl_byteenable_q;
  logic              imem_ready_q;
  logic              imem_error_q;
  logic [31:0]       imem_rdata_q;
  logic              dmem_ready_q;
  logic              dmem_error_q;
  logic [31:0]       dmem_rdata_q;

  logic              imem_req_d;
  logic              dmem_req_d;
  logic              any_req_d;
  logic              grant_dmem_d;
  logic              req_write_d;
  logic              in_window_d;
  logic [31:0]       req_addr_d;
  logic [31:0]       offset_d;

  // A port whose ready is pulsing this cycle still holds valid; mask it so the
  // finished request is not granted a second time.
  assign imem_req_d   = imem_valid && !imem_ready_q;
  assign dmem_req_d   = dmem_valid && !dmem_ready_q;
  assign any_req_d    = imem_req_d || dmem_req_d;
  assign grant_dmem_d = dmem_req_d && (!imem_req_d || (last_q == PORT_IMEM));
  assign req_write_d  = grant_dmem_d && (dmem_wstrb != 4'h0);
  assign req_addr_d   = grant_dmem_d ? dmem_addr : imem_addr;
  assign in_window_d  = (req_addr_d >= avl_base_addr) && (req_addr_d < avl_top_addr);
  assign offset_d     = (req_addr_d - avl_base_addr) & 32'hFFFF_FFFC;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= S_IDLE;
      last_q           <= PORT_IMEM;
      port_q           <= PORT_IMEM;
      is_write_q       <= 1'b0;
      wd_q             <= '0;
      resp_err_q       <= 1'b0;
      resp_rdata_q     <= 32'h0;
      avl_address_q    <= 32'h0;
      avl_read_q       <= 1'b0;
      avl_write_q      <= 1'b0;
      avl_writedata_q  <= 32'h0;
      avl_byteenable_q <= 4'h0;
      imem_ready_q     <= 1'b0;
      imem_error_q     <= 1'b0;
      imem_rdata_q     <= 32'h0;
      dmem_ready_q     <= 1'b0;
      dmem_error_q     <= 1'b0;
      dmem_rdata_q     <= 32'h0;
    end else begin
      imem_ready_q <= 1'b0;
      imem_error_q <= 1'b0;
      imem_rdata_q <= 32'h0;
      dmem_ready_q <= 1'b0;
      dmem_error_q <= 1'b0;
      dmem_rdata_q <= 32'h0;

      case (state_q)
        S_IDLE: begin
          if (any_req_d) begin
            port_q     <= grant_dmem_d;
            is_write_q <= req_write_d;
            if (in_window_d) begin
              avl_address_q    <= offset_d;
              avl_read_q       <= !req_write_d;
              avl_write_q      <= req_write_d;
              avl_writedata_q  <= grant_dmem_d ? dmem_wdata : 32'h0;
              avl_byteenable_q <= req_write_d ? dmem_wstrb : 4'hF;
              state_q          <= S_CMD;
            end else begin
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'h0;
              state_q      <= S_RESP;
            end
          end
        end

        S_CMD: begin
          if (!avl_waitrequest) begin
            avl_address_q    <= 32'h0;
            avl_read_q       <= 1'b0;
            avl_write_q      <= 1'b0;
            avl_writedata_q  <= 32'h0;
            avl_byteenable_q <= 4'h0;
            if (is_write_q) begin
              resp_err_q   <= 1'b0;
              resp_rdata_q <= 32'h0;
              state_q      <= S_RESP;
            end else begin
              wd_q    <= '0;
              state_q <= S_RDWAIT;
            end
          end
        end

        // readdatavalid is only honoured here, so early or stray beats are dropped.
        S_RDWAIT: begin
          if (avl_readdatavalid) begin
            resp_err_q   <= 1'b0;
            resp_rdata_q <= avl_readdata;
            state_q      <= S_RESP;
          end else if (wd_q == WD_LAST) begin
            resp_err_q   <= 1'b1;
            resp_rdata_q <= 32'h0;
            state_q      <= S_RESP;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end

        S_RESP: begin
          if (port_q == PORT_DMEM) begin
            dmem_ready_q <= 1'b1;
            dmem_error_q <= resp_err_q;
            dmem_rdata_q <= resp_rdata_q;
          end else begin
            imem_ready_q <= 1'b1;
            imem_error_q <= resp_err_q;
            imem_rdata_q <= resp_rdata_q;
          end
          last_q  <= port_q;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem_ready     = imem_ready_q;
  assign imem_error     = imem_error_q;
  assign imem_rdata     = imem_rdata_q;
  assign dmem_ready     = dmem_ready_q;
  assign dmem_error     = dmem_error_q;
  assign dmem_rdata     = dmem_rdata_q;
  assign avl_address    = avl_address_q;
  assign avl_read       = avl_read_q;
  assign avl_write      = avl_write_q;
  assign avl_writedata  = avl_writedata_q;
  assign avl_byteenable = avl_byteenable_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_avl_arbiter.sv
// Directed bench for avl_arbiter: expected responses are queued at issue time and
// checked by a ready monitor; a small Avalon slave model supplies wait/latency.
module tb_avl_arbiter;
  import avl_arbiter_pkg::*;

  localparam int unsigned TO = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_valid, dmem_valid;
  logic [31:0] imem_addr, dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] imem_rdata, dmem_rdata;
  logic        imem_ready, dmem_ready, imem_error, dmem_error;
  logic [31:0] avl_address, avl_writedata;
  logic        avl_read, avl_write;
  logic [3:0]  avl_byteenable;
  logic        avl_waitrequest = 1'b0;
  logic [31:0] avl_readdata = 32'h0;
  logic        avl_readdatavalid = 1'b0;
  logic [1:0]  dbg_state;

  avl_arbiter #(.timeout_cycles(TO)) dut (
    .clock(clock), .reset(reset),
    .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .imem_error(imem_error),
    .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .dmem_error(dmem_error),
    .avl_address(avl_address), .avl_read(avl_read), .avl_write(avl_write),
    .avl_writedata(avl_writedata), .avl_byteenable(avl_byteenable),
    .avl_waitrequest(avl_waitrequest), .avl_readdata(avl_readdata),
    .avl_readdatavalid(avl_readdatavalid), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- checking helpers ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- Avalon slave model ----------------
  int          slv_wait = 0;
  int          slv_lat  = 1;
  logic        slv_fixed = 1'b0;
  logic [31:0] slv_rdata = 32'h0;
  int          wcnt = 0;
  int          pend = 0;
  logic [31:0] pend_data = 32'h0;

  always @(negedge clock) begin
    avl_readdatavalid = 1'b0;
    avl_readdata      = 32'h0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        avl_readdatavalid = 1'b1;
        avl_readdata      = pend_data;
      end
    end
    if (avl_read || avl_write) begin
      if (wcnt < slv_wait) begin
        avl_waitrequest = 1'b1;
        wcnt++;
      end else begin
        avl_waitrequest = 1'b0;
        wcnt = 0;
        if (avl_read && slv_lat > 0) begin
          pend      = slv_lat;
          pend_data = slv_fixed ? slv_rdata : {16'hC0DE, avl_address[15:0]};
        end
      end
    end else begin
      avl_waitrequest = 1'b0;
      wcnt = 0;
    end
  end

  // ---------------- Avalon command monitor ----------------
  int          cmd_count = 0;
  int          cmd_cycles = 0;
  logic        cmd_active = 1'b0;
  logic [31:0] cmd_addr = 32'h0;
  logic [31:0] cmd_wdata = 32'h0;
  logic [3:0]  cmd_be = 4'h0;
  logic        cmd_wr = 1'b0;

  always @(negedge clock) begin
    if (avl_read || avl_write) begin
      check("rw_onehot", 32'(avl_read ^ avl_write), 32'd1);
      if (!cmd_active) begin
        cmd_count++;
        cmd_cycles = 1;
        cmd_addr   = avl_address;
        cmd_wdata  = avl_writedata;
        cmd_be     = avl_byteenable;
        cmd_wr     = avl_write;
      end else begin
        cmd_cycles++;
        check("cmd_addr_stable", avl_address, cmd_addr);
        check("cmd_be_stable", 32'(avl_byteenable), 32'(cmd_be));
      end
      cmd_active = 1'b1;
    end else begin
      cmd_active = 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  // entry: {port(1), error(1), latency(8, 0 = unchecked), rdata(32)}
  logic [41:0] exp_q[$];
  int          imem_issue = 0;
  int          dmem_issue = 0;
  logic [41:0] e;

  always @(negedge clock) begin
    if (!reset && (imem_ready || dmem_ready)) begin
      if (dmem_ready) begin
        check("imem_quiet", 32'({imem_ready, imem_error}), 32'd0);
        check("imem_rdata_quiet", imem_rdata, 32'h0);
      end else begin
        check("dmem_quiet", 32'({dmem_ready, dmem_error}), 32'd0);
        check("dmem_rdata_quiet", dmem_rdata, 32'h0);
      end
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: imem_ready=%0b dmem_ready=%0b with nothing expected (cycle %0d)",
                 imem_ready, dmem_ready, cyc);
      end else begin
        e = exp_q.pop_front();
        check("resp_port", 32'(dmem_ready), 32'(e[41]));
        check("resp_error", 32'(dmem_ready ? dmem_error : imem_error), 32'(e[40]));
        check("resp_rdata", dmem_ready ? dmem_rdata : imem_rdata, e[31:0]);
        if (e[39:32] != 8'd0)
          check("resp_latency", 32'(cyc - (dmem_ready ? dmem_issue : imem_issue)), 32'(e[39:32]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input logic p, input logic er, input int lat, input logic [31:0] rd);
    exp_q.push_back({p, er, 8'(lat), rd});
  endtask

  task automatic issue_imem(input logic [31:0] a);
    imem_addr  = a;
    imem_valid = 1'b1;
    imem_issue = cyc;
  endtask

  task automatic issue_dmem(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
    dmem_addr  = a;
    dmem_wdata = wd;
    dmem_wstrb = st;
    dmem_valid = 1'b1;
    dmem_issue = cyc;
  endtask

  // Requesters drop valid once they see their ready; bounded wait.
  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((imem_valid || dmem_valid) && n < budget) begin
      @(negedge clock);
      n++;
      if (imem_ready) imem_valid = 1'b0;
      if (dmem_ready) dmem_valid = 1'b0;
    end
    total++;
    if (imem_valid || dmem_valid) begin
      bad++;
      $display("FAIL wait_done: requests still pending after %0d cycles (imem=%0b dmem=%0b)",
               budget, imem_valid, dmem_valid);
      imem_valid = 1'b0;
      dmem_valid = 1'b0;
    end
    @(negedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
    check({tag, "_ready"}, 32'({imem_ready, dmem_ready, imem_error, dmem_error}), 32'd0);
    check({tag, "_rdata"}, imem_rdata | dmem_rdata, 32'h0);
    check({tag, "_avl_rw"}, 32'({avl_read, avl_write}), 32'd0);
    check({tag, "_avl_addr"}, avl_address | avl_writedata, 32'h0);
    check({tag, "_avl_be"}, 32'(avl_byteenable), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  int c0;
  int n;

  initial begin
    reset = 1'b1;
    imem_valid = 1'b0; imem_addr = 32'h0;
    dmem_valid = 1'b0; dmem_addr = 32'h0; dmem_wdata = 32'h0; dmem_wstrb = 4'h0;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clock);

    // Tie straight out of reset: dmem first, imem granted right after dmem_ready.
    push_exp(PORT_DMEM, 1'b0, 4, 32'hC0DE_0040);
    push_exp(PORT_IMEM, 1'b0, 8, 32'hC0DE_0080);
    issue_dmem(32'h8000_0040, 32'h0, 4'h0);
    issue_imem(32'h8000_0080);
    wait_done(40);

    // Last served was imem, so dmem wins this tie.
    push_exp(PORT_DMEM, 1'b0, 4, 32'hC0DE_0044);
    push_exp(PORT_IMEM, 1'b0, 8, 32'hC0DE_0084);
    issue_dmem(32'h8000_0044, 32'h0, 4'h0);
    issue_imem(32'h8000_0084);
    wait_done(40);

    // dmem read, readdatavalid one cycle after accept.
    slv_fixed = 1'b1;
    slv_rdata = 32'hDEAD_BEEF;
    c0 = cmd_count;
    push_exp(PORT_DMEM, 1'b0, 4, 32'hDEAD_BEEF);
    issue_dmem(32'h8000_0010, 32'h0, 4'h0);
    wait_done(40);
    check("rd_cmd_count", 32'(cmd_count), 32'(c0 + 1));
    check("rd_addr", cmd_addr, 32'h0000_0010);
    check("rd_be", 32'(cmd_be), 32'hF);
    check("rd_kind", 32'(cmd_wr), 32'd0);
    check("rd_cycles", 32'(cmd_cycles), 32'd1);
    slv_fixed = 1'b0;

    // Last served was dmem, so imem wins this tie.
    push_exp(PORT_IMEM, 1'b0, 4, 32'hC0DE_0100);
    push_exp(PORT_DMEM, 1'b0, 8, 32'hC0DE_0104);
    issue_dmem(32'h8000_0104, 32'h0, 4'h0);
    issue_imem(32'h8000_0100);
    wait_done(40);

    // Write held under three cycles of waitrequest.
    slv_wait = 3;
    push_exp(PORT_DMEM, 1'b0, 6, 32'h0);
    issue_dmem(32'h8000_0004, 32'h1234_5678, 4'h3);
    wait_done(40);
    check("wr_kind", 32'(cmd_wr), 32'd1);
    check("wr_cycles", 32'(cmd_cycles), 32'd4);
    check("wr_be", 32'(cmd_be), 32'h3);
    check("wr_data", cmd_wdata, 32'h1234_5678);
    check("wr_addr", cmd_addr, 32'h0000_0004);
    slv_wait = 0;

    // Write without waitstates: minimum write latency.
    push_exp(PORT_DMEM, 1'b0, 3, 32'h0);
    issue_dmem(32'h8000_0008, 32'hCAFE_F00D, 4'hF);
    wait_done(40);
    check("wr2_be", 32'(cmd_be), 32'hF);
    check("wr2_data", cmd_wdata, 32'hCAFE_F00D);

    // Out-of-window cases never touch the bus.
    c0 = cmd_count;
    push_exp(PORT_IMEM, 1'b1, 2, 32'h0);
    issue_imem(32'h0000_1000);
    wait_done(40);
    push_exp(PORT_DMEM, 1'b1, 2, 32'h0);
    issue_dmem(32'h9000_0000, 32'h0, 4'h0);
    wait_done(40);
    push_exp(PORT_DMEM, 1'b1, 2, 32'h0);
    issue_dmem(32'h7FFF_FFFC, 32'h0, 4'h0);
    wait_done(40);
    push_exp(PORT_DMEM, 1'b1, 2, 32'h0);
    issue_dmem(32'hFFFF_FFFF, 32'h5555_AAAA, 4'hF);
    wait_done(40);
    check("oow_no_cmd", 32'(cmd_count), 32'(c0));

    // Last byte of the window is in range; low address bits forced to zero.
    push_exp(PORT_DMEM, 1'b0, 4, 32'hC0DE_FFFC);
    issue_dmem(32'h8FFF_FFFF, 32'h0, 4'h0);
    wait_done(40);
    check("edge_addr", cmd_addr, 32'h0FFF_FFFC);
    push_exp(PORT_IMEM, 1'b0, 4, 32'hC0DE_0010);
    issue_imem(32'h8000_0013);
    wait_done(40);
    check("lowbits_addr", cmd_addr, 32'h0000_0010);

    // Watchdog: no data within the limit, stray beat arrives later and is dropped.
    slv_lat = 12;
    push_exp(PORT_IMEM, 1'b1, 11, 32'h0);
    issue_imem(32'h8000_0020);
    wait_done(40);
    repeat (8) @(negedge clock);
    check("post_stray_state", 32'(dbg_state), 32'(S_IDLE));

    // Reset while waiting for read data: abandoned, then the held valid is served.
    slv_lat = 0;
    push_exp(PORT_IMEM, 1'b0, 0, 32'hC0DE_0200);
    issue_imem(32'h8000_0200);
    n = 0;
    while (dbg_state != S_RDWAIT && n < 10) begin
      @(negedge clock);
      n++;
    end
    check("reach_rdwait", 32'(dbg_state), 32'(S_RDWAIT));
    reset = 1'b1;
    @(negedge clock);
    check_all_zero("mid_reset");
    slv_lat = 1;
    reset = 1'b0;
    wait_done(40);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
